// File: rtl/fifo_read_arbiter_8to1.sv
// fifo_read_arbiter_8to1
// Drains eight per-channel FIFOs onto one valid/ready stream. A round-robin
// arbiter grants a non-empty, unmasked channel, pulses its rd_en once, waits
// out the FIFO read latency, captures the word and holds it until accepted.
module fifo_read_arbiter_8to1 #(
    parameter int DATA_WIDTH = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [7:0]            ch_mask,
    input  logic [7:0]            empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout0,
    input  logic [DATA_WIDTH-1:0] fifo_dout1,
    input  logic [DATA_WIDTH-1:0] fifo_dout2,
    input  logic [DATA_WIDTH-1:0] fifo_dout3,
    input  logic [DATA_WIDTH-1:0] fifo_dout4,
    input  logic [DATA_WIDTH-1:0] fifo_dout5,
    input  logic [DATA_WIDTH-1:0] fifo_dout6,
    input  logic [DATA_WIDTH-1:0] fifo_dout7,
    output logic [7:0]            rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            dout_addr,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy
);

    // Latency counter only needs to reach 3 (legal range 1..3).
    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [2:0]            sel_q, sel_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [2:0]            dout_addr_q, dout_addr_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  busy_q, busy_d;

    logic [7:0]            eligible;
    logic                  grant_found;
    logic [2:0]            grant_idx;
    logic [2:0]            scan_idx;
    logic [DATA_WIDTH-1:0] fifo_sel;

    assign eligible = ~empty & ch_mask;

    // Round-robin pick: scan downward from ptr+7 to ptr so the lowest offset
    // from ptr is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        scan_idx    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr_q + 3'(k);
            if (eligible[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Read-data mux for the channel currently being serviced.
    always_comb begin
        case (sel_q)
            3'd0:    fifo_sel = fifo_dout0;
            3'd1:    fifo_sel = fifo_dout1;
            3'd2:    fifo_sel = fifo_dout2;
            3'd3:    fifo_sel = fifo_dout3;
            3'd4:    fifo_sel = fifo_dout4;
            3'd5:    fifo_sel = fifo_dout5;
            3'd6:    fifo_sel = fifo_dout6;
            default: fifo_sel = fifo_dout7;
        endcase
    end

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        rd_en_d      = rd_en_q;
        dout_d       = dout_q;
        dout_addr_d  = dout_addr_q;
        dout_valid_d = dout_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (en && grant_found) begin
                    sel_d   = grant_idx;
                    rd_en_d = 8'h01 << grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_en_d = 8'h00;
                cnt_d   = 2'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == LAT) begin
                    dout_d       = fifo_sel;
                    dout_addr_d  = sel_q;
                    dout_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    ptr_d        = sel_q + 3'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 3'd0;
            sel_q        <= 3'd0;
            cnt_q        <= 2'd0;
            rd_en_q      <= 8'h00;
            dout_q       <= '0;
            dout_addr_q  <= 3'd0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            rd_en_q      <= rd_en_d;
            dout_q       <= dout_d;
            dout_addr_q  <= dout_addr_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign dout       = dout_q;
    assign dout_addr  = dout_addr_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_read_arbiter_8to1.sv
// Directed bench for fifo_read_arbiter_8to1: one DUT at RD_LATENCY=1 and one
// at RD_LATENCY=3 sharing stimulus.
module tb_fifo_read_arbiter_8to1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en;
    logic [7:0]   ch_mask;
    logic [7:0]   empty;
    logic [127:0] fd [8];
    logic         dout_ready;

    logic [7:0]   rd_en,  rd_en3;
    logic [127:0] dout,   dout3;
    logic [2:0]   addr,   addr3;
    logic         valid,  valid3;
    logic         busy,   busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_read_arbiter_8to1 #(.DATA_WIDTH(128), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .empty(empty),
        .fifo_dout0(fd[0]), .fifo_dout1(fd[1]), .fifo_dout2(fd[2]), .fifo_dout3(fd[3]),
        .fifo_dout4(fd[4]), .fifo_dout5(fd[5]), .fifo_dout6(fd[6]), .fifo_dout7(fd[7]),
        .rd_en(rd_en), .dout(dout), .dout_addr(addr), .dout_valid(valid),
        .dout_ready(dout_ready), .busy(busy)
    );

    fifo_read_arbiter_8to1 #(.DATA_WIDTH(128), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .empty(empty),
        .fifo_dout0(fd[0]), .fifo_dout1(fd[1]), .fifo_dout2(fd[2]), .fifo_dout3(fd[3]),
        .fifo_dout4(fd[4]), .fifo_dout5(fd[5]), .fifo_dout6(fd[6]), .fifo_dout7(fd[7]),
        .rd_en(rd_en3), .dout(dout3), .dout_addr(addr3), .dout_valid(valid3),
        .dout_ready(dout_ready), .busy(busy3)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges, release mid-cycle.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        step();
        step();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b0; ch_mask = 8'hFF; empty = 8'hFF; dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) fd[i] = {16{8'hC0 + 8'(i)}};
        fd[2] = {16{8'hA5}};
        #1 rst_n = 1'b0;
        #3;
        total++; if (rd_en !== 8'h00) begin bad++; $display("FAIL reset_rd_en got=%h exp=00", rd_en); end
        total++; if (dout !== 128'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
        total++; if (addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr); end
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%b%b exp=00", valid, busy); end
        total++; if (rd_en3 !== 8'h00 || valid3 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL reset_dut3 got=%h/%b/%b exp=00/0/0", rd_en3, valid3, busy3); end
        step();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single();
        en = 1'b1; ch_mask = 8'hFF; empty = 8'hFB; dout_ready = 1'b1;
        step();
        total++; if (rd_en !== 8'h04) begin bad++; $display("FAIL single_rd_en got=%h exp=04", rd_en); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        empty = 8'hFF;
        step();
        total++; if (rd_en !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL single_e1 got=%h/%b exp=00/0", rd_en, valid); end
        step();
        total++; if (valid !== 1'b1 || dout !== {16{8'hA5}} || addr !== 3'd2) begin bad++; $display("FAIL single_word got=%b/%h/%0d exp=1/a5..a5/2", valid, dout, addr); end
        $display("single: ch=%0d data=%h", addr, dout);
        step();
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_accept got=%b/%b exp=0/0", valid, busy); end
        empty = 8'h00;
        step();
        total++; if (rd_en !== 8'h08) begin bad++; $display("FAIL single_next_ptr got=%h exp=08", rd_en); end
        empty = 8'hFF;
        step(); step(); step();
    endtask

    task automatic test_round_robin();
        int ngrant = 0;
        int nvalid = 0;
        int last_rise = 0;
        logic [7:0] exp_rd;
        logic [2:0] exp_ch;
        do_reset();
        en = 1'b1; ch_mask = 8'hFF; empty = 8'h00; dout_ready = 1'b1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            step();
            if (rd_en !== 8'h00) begin
                exp_rd = 8'h01 << (ngrant % 8);
                total++; if (rd_en !== exp_rd) begin bad++; $display("FAIL rr_grant got=%h exp=%h", rd_en, exp_rd); end
                if (ngrant > 0) begin
                    total++; if (cyc - last_rise != 4) begin bad++; $display("FAIL rr_spacing got=%0d exp=4", cyc - last_rise); end
                end
                last_rise = cyc;
                ngrant++;
            end
            if (valid === 1'b1) begin
                exp_ch = 3'(nvalid % 8);
                total++; if (addr !== exp_ch || dout !== fd[exp_ch]) begin bad++; $display("FAIL rr_word got=%0d/%h exp=%0d/%h", addr, dout, exp_ch, fd[exp_ch]); end
                $display("rr: word %0d ch=%0d data=%h", nvalid, addr, dout);
                nvalid++;
            end
        end
        total++; if (nvalid < 10) begin bad++; $display("FAIL rr_count got=%0d exp>=10", nvalid); end
        empty = 8'hFF;
        step(); step(); step(); step();
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; ch_mask = 8'hFF; empty = 8'hDF; dout_ready = 1'b0;
        step();
        total++; if (rd_en !== 8'h20) begin bad++; $display("FAIL bp_grant got=%h exp=20", rd_en); end
        step(); step();
        total++; if (valid !== 1'b1 || addr !== 3'd5 || dout !== fd[5]) begin bad++; $display("FAIL bp_word got=%b/%0d/%h exp=1/5/%h", valid, addr, dout, fd[5]); end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (valid !== 1'b1 || addr !== 3'd5 || dout !== fd[5] || rd_en !== 8'h00) begin
                bad++; $display("FAIL bp_stall%0d got=%b/%0d/%h/%h exp=1/5/%h/00", i, valid, addr, dout, rd_en, fd[5]);
            end
        end
        $display("bp: ch=%0d data=%h held 10 cycles", addr, dout);
        dout_ready = 1'b1; empty = 8'hFF;
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", valid); end
        step(); step(); step();
    endtask

    task automatic test_mask_enable();
        logic seen;
        do_reset();
        en = 1'b1; ch_mask = 8'h0F; empty = 8'h0F; dout_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); if (rd_en !== 8'h00 || busy !== 1'b0) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mask_block got=rd_en_seen exp=none"); end
        en = 1'b0; ch_mask = 8'hFF; empty = 8'hFE;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); if (rd_en !== 8'h00 || busy !== 1'b0) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL en_block got=rd_en_seen exp=none"); end
        en = 1'b1; empty = 8'h0F;
        step();
        total++; if (rd_en !== 8'h10) begin bad++; $display("FAIL mask_first got=%h exp=10", rd_en); end
        empty = 8'hFF;
        step(); step(); step(); step();
    endtask

    task automatic test_latency3();
        logic [127:0] good;
        good = {4{32'h7777_1234}};
        do_reset();
        en = 1'b1; ch_mask = 8'hFF; empty = 8'h7F; dout_ready = 1'b1;
        fd[7] = {4{32'hDEAD_BEEF}};
        step();
        total++; if (rd_en3 !== 8'h80) begin bad++; $display("FAIL lat_grant got=%h exp=80", rd_en3); end
        empty = 8'hFF;
        step(); step(); step();
        fd[7] = good;
        total++; if (valid3 !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", valid3); end
        step();
        total++; if (valid3 !== 1'b1 || dout3 !== good || addr3 !== 3'd7) begin bad++; $display("FAIL lat_word got=%b/%h/%0d exp=1/%h/7", valid3, dout3, addr3, good); end
        $display("lat3: ch=%0d data=%h", addr3, dout3);
        step();
        total++; if (valid3 !== 1'b0) begin bad++; $display("FAIL lat_accept got=%b exp=0", valid3); end
        empty = 8'h00;
        step();
        total++; if (rd_en3 !== 8'h01) begin bad++; $display("FAIL lat_wrap got=%h exp=01", rd_en3); end
        empty = 8'hFF;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_async_reset();
        // Reset while in WAIT.
        do_reset();
        en = 1'b1; ch_mask = 8'hFF; empty = 8'hFD; dout_ready = 1'b0;
        step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_wait_busy got=%b exp=1", busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rd_en !== 8'h00 || valid !== 1'b0 || dout !== 128'h0 || busy !== 1'b0) begin bad++; $display("FAIL ar_wait got=%h/%b/%h/%b exp=00/0/0/0", rd_en, valid, dout, busy); end
        step();
        #2 rst_n = 1'b1;
        // Reset while in HOLD.
        step(); step(); step();
        total++; if (valid !== 1'b1 || dout !== fd[1]) begin bad++; $display("FAIL ar_hold_pre got=%b/%h exp=1/%h", valid, dout, fd[1]); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rd_en !== 8'h00 || valid !== 1'b0 || dout !== 128'h0 || addr !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL ar_hold got=%h/%b/%h/%0d/%b exp=00/0/0/0/0", rd_en, valid, dout, addr, busy); end
        step();
        empty = 8'hFC;
        #2 rst_n = 1'b1;
        step();
        total++; if (rd_en !== 8'h01) begin bad++; $display("FAIL ar_restart got=%h exp=01", rd_en); end
        empty = 8'hFF; dout_ready = 1'b1;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask_enable();
        test_latency3();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_read_arbiter_8to1.md
# fifo_read_arbiter_8to1

Read-side counterpart of the 1-to-8 write demultiplexer: drains eight independent 128-bit channel FIFOs onto a single output stream. A round-robin arbiter picks a non-empty channel and issues a single-cycle `rd_en`. It waits out the FIFO read latency, captures the word, and presents it with the source channel index on a valid/ready output port. The block sits between the eight per-channel FIFOs and the downstream consumer in the dynamic controller datapath.

## Interface
- `DATA_WIDTH`, 128, width of every FIFO word and of `dout`.
- `RD_LATENCY`, 1, FIFO read latency in cycles (legal 1..3): data valid on FIFO `dout` this many cycles after the edge that samples `rd_en` high.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; new arbitration happens only when high.
- `ch_mask`  in  8  per-channel enable; bit i=0 excludes channel i from arbitration.
- `empty`  in  8  FIFO empty flags, bit i = channel i.
- `fifo_dout0`..`fifo_dout7`  in  DATA_WIDTH each  FIFO read data, channel 0..7.
- `rd_en`  out  8  FIFO read strobes, registered, at most one bit high.
- `dout`  out  DATA_WIDTH  captured word.
- `dout_addr`  out  3  channel index of `dout`.
- `dout_valid`  out  1  `dout`/`dout_addr` valid.
- `dout_ready`  in  1  consumer accepts when high with `dout_valid`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD. Reset state IDLE.
- IDLE, eligibility: channel i is eligible when `empty[i]=0` and `ch_mask[i]=1`.
- IDLE, arbitration: if `en=1` and any channel is eligible, grant the first eligible channel scanning upward from `ptr` with wrap 7->0.
- IDLE, on grant: `sel<=grant`, `rd_en[grant]<=1`, go to ISSUE.
- IDLE, otherwise: stay in IDLE.
- ISSUE: `rd_en<=0`, latency counter `cnt<=1`, go to WAIT. Exactly one `rd_en` pulse is issued per grant.
- WAIT: while `cnt<RD_LATENCY`, increment `cnt`.
- WAIT, on `cnt==RD_LATENCY`: `dout<=fifo_dout[sel]`, `dout_addr<=sel`, `dout_valid<=1`, go to HOLD.
- HOLD: `dout`, `dout_addr` and `dout_valid` hold stable until `dout_ready=1`.
- HOLD, on accept: `dout_valid<=0`, `ptr<=sel+1` (3-bit wrap, 7->0), go to IDLE.
- Changes to `empty`, `ch_mask` and `en` outside IDLE are ignored and do not abort a read in flight.
- `en` dropping in HOLD still completes the handshake.
- `dout_ready` is ignored outside HOLD.
- Reset values, all outputs: `rd_en=8'h00`, `dout=0`, `dout_addr=0`, `dout_valid=0`, `busy=0`.
- Reset values, internal: `ptr=0`, `sel=0`, `cnt=0`.
- Reset mid-operation: everything returns immediately to reset values. A word already popped from a FIFO is discarded; this is accepted behaviour.
- Output port is single-entry and unbuffered: no new `rd_en` is issued while `dout_valid=1`.

## Timing
- Let edge E0 be the edge at which IDLE grants.
- `rd_en[g]` is high for exactly the cycle between E0 and E1.
- `dout_valid` rises at edge E(1+RD_LATENCY): E2 for RD_LATENCY=1.
- With `dout_ready` held high, `dout_valid` is high for one cycle and falls at E(2+RD_LATENCY). The FSM is in IDLE after that edge.
- Earliest next `rd_en` rises at E(3+RD_LATENCY).
- Peak throughput is one word per RD_LATENCY+3 cycles: 4 cycles at RD_LATENCY=1.
- Grant path depends only on registered `ptr` and the inputs `empty`, `ch_mask`, `en`.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset, single channel:
  - Stimulus: `rst_n` low, then high; `empty=8'hFB` (channel 2 non-empty), `fifo_dout2=128'hA5..A5`, `dout_ready=1`, `en=1`, `ch_mask=8'hFF`.
  - Required: `rd_en=8'h04` for one cycle; `dout_valid` high 2 cycles later with `dout=128'hA5..A5`, `dout_addr=2`; then `ptr=3`.
- Round-robin fairness with wrap:
  - Stimulus: all channels non-empty continuously, `dout_ready=1`.
  - Required: `dout_addr` sequence 0,1,2,3,4,5,6,7,0,1; consecutive `rd_en` rises spaced exactly 4 cycles apart.
- Backpressure:
  - Stimulus: channel 5 non-empty; hold `dout_ready=0` for 10 cycles after `dout_valid` rises, then 1.
  - Required: `dout`, `dout_addr=5` and `dout_valid` stable for all 10 cycles; no `rd_en` pulse during the stall; `dout_valid` falls one edge after `dout_ready` rises.
- Masking and enable:
  - Stimulus: `ch_mask=8'h0F` with channels 4..7 non-empty; then set `en=0` with channel 0 non-empty.
  - Required: no `rd_en` in either case; after `ch_mask=8'hFF`, `en=1`, channel 4 is granted first.
- Latency parameter:
  - Stimulus: instantiate with `RD_LATENCY=3`; read channel 7 with `fifo_dout7` driven valid only from the 3rd edge after `rd_en` rises.
  - Required: `dout_valid` rises at E4 with the correct data; `dout_addr=7`; `ptr` wraps to 0.
- Async reset mid-read:
  - Stimulus: assert `rst_n` low asynchronously (between clock edges) while in WAIT, and again while in HOLD.
  - Required: `rd_en=0`, `dout_valid=0`, `dout=0`, `busy=0` immediately, without waiting for a clock edge; after release, arbitration restarts from channel 0.
